parity_serial_arbiter: RTL and testbench

- Shares one serial parity datapath between NREQ parallel-word requesters.
- Round-robin arbiter grants one requester, latches its word and expected parity bit, then shifts the word out LSB-first one bit per clock.
- Serial parity is accumulated as the bits shift out; a pass/fail result is reported, tagged with the requester ID.
- Sits in front of the serial parity logic as its scheduler and sequencer.

---
 rtl/parity_serial_arbiter_pkg.sv | 14 +
 rtl/parity_serial_arbiter_if.sv | 30 +++
 rtl/parity_serial_arbiter_accum.sv | 26 ++
 rtl/parity_serial_arbiter.sv | 153 +++++++++++++++
 tb/tb_parity_serial_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_serial_arbiter_pkg.sv
// Shared types and constants for the round-robin serial parity arbiter.
package parity_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam bit PAR_EVEN  = 1'b0;
  localparam bit PAR_ODD   = 1'b1;
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/parity_serial_arbiter_if.sv
// Requester bus plus serial/result outputs of the parity arbiter.
interface parity_serial_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_par;
  logic [NREQ-1:0]       req_ready;
  logic                  ser_bit;
  logic                  ser_valid;
  logic                  res_valid;
  logic [ID_W-1:0]       res_id;
  logic                  res_parity;
  logic                  res_ok;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_par,
    input  req_ready, ser_bit, ser_valid, res_valid, res_id, res_parity, res_ok, busy
  );

  modport slave (
    input  req_valid, req_data, req_par,
    output req_ready, ser_bit, ser_valid, res_valid, res_id, res_parity, res_ok, busy
  );

endinterface

// File: rtl/parity_serial_arbiter_accum.sv
// Serial XOR accumulator: folds one bit per valid cycle into a running parity.
module parity_bit_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic parity
);

  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clr)            parity_d = 1'b0;
    else if (bit_valid) parity_d = parity_q ^ bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign parity = parity_q;

endmodule

// File: rtl/parity_serial_arbiter.sv
// Round-robin scheduler that serialises one requester word at a time through a parity check.
// Optional per-requester saturating error counters are enabled by defining PARITY_ERR_CNT_EN.
module parity_serial_arbiter
  import parity_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int ODD   = 0
) (
  input logic clk,
  input logic rst,
  parity_serial_arbiter_if.slave bus
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [NREQ*ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NREQ - 1);
  localparam bit PAR_SENSE = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             exp_par_q, exp_par_d;
  logic             ser_valid_q, ser_valid_d;
  logic             res_valid_q, res_valid_d;

  logic [ID_W-1:0]  grant, cand;
  logic             grant_hit, accept, acc_parity, res_parity, res_ok;

  // First valid requester after the last grant, wrapping around.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    cand      = '0;
    grant_hit = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = ID_W'((int'(last_q) + i) % NREQ);
      if (!grant_hit && bus.req_valid[cand]) begin
        grant_hit = 1'b1;
        grant     = cand;
      end
    end
  end

  assign accept = grant_hit && (state_q == IDLE) && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    exp_par_d   = exp_par_q;
    ser_valid_d = ser_valid_q;
    res_valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        shreg_d     = bus.req_data[int'(grant)*WIDTH +: WIDTH];
        exp_par_d   = bus.req_par[grant];
        id_d        = grant;
        last_d      = grant;
        cnt_d       = '0;
        ser_valid_d = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          ser_valid_d = 1'b0;
          res_valid_d = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all of them update from the same pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      last_q      <= PTR_RST;
      id_q        <= '0;
      exp_par_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      exp_par_q   <= exp_par_d;
      ser_valid_q <= ser_valid_d;
      res_valid_q <= res_valid_d;
    end
  end

  parity_bit_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_valid (state_q == SHIFT),
    .bit_in    (shreg_q[0]),
    .parity    (acc_parity)
  );

  assign res_parity     = acc_parity ^ PAR_SENSE;
  assign res_ok         = (res_parity == exp_par_q);

  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_bit    = ser_valid_q & shreg_q[0];
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_valid_q ? id_q : '0;
  assign bus.res_parity = res_valid_q & res_parity;
  assign bus.res_ok     = res_valid_q & res_ok;
  assign bus.busy       = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
  logic [NREQ-1:0][ERR_CNT_W-1:0] err_q, err_d;

  // Saturating: a counter parked at all-ones stays there.
  always_comb begin
    err_d = err_q;
    if (res_valid_q && !res_ok && (err_q[id_q] != '1))
      err_d[id_q] = err_q[id_q] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_parity_serial_arbiter.sv
// Directed bench for parity_serial_arbiter with a timeline model checked every cycle.
module tb_parity_serial_arbiter;
  import parity_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int ODD   = 0;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parity_serial_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef PARITY_ERR_CNT_EN
  logic [NREQ*ERR_CNT_W-1:0] err_cnt;
`endif

  parity_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ODD(ODD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  // Observations of the DUT, used by the literal checks.
  bit ser_q[$];
  int acc_cyc_q[$];
  int acc_id_q[$];
  int busy_low_q[$];
  int res_cnt = 0;

  // Model: a word accepted on cycle T shows bit k-1 on cycle T+k and its result on T+WIDTH+1.
  int               m_start = -1;
  logic [WIDTH-1:0] m_word;
  logic             m_par;
  int               m_id;
  int               m_last = NREQ - 1;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int k, acc;
        logic [NREQ-1:0] e_ready;
        logic e_sv, e_sb, e_rv, e_rp, e_ok, e_busy;
        logic [1:0] e_id;
        k = (m_start >= 0) ? cyc - m_start : 0;
        acc = -1;
        e_ready = '0; e_sv = 0; e_sb = 0; e_rv = 0; e_rp = 0; e_ok = 0; e_busy = 0; e_id = '0;
        if (m_start >= 0 && k >= 1 && k <= WIDTH) begin
          e_busy = 1; e_sv = 1; e_sb = m_word[k-1];
        end else if (m_start >= 0 && k == WIDTH + 1) begin
          e_busy = 1; e_rv = 1; e_id = 2'(m_id);
          e_rp = (^m_word) ^ (ODD != 0);
          e_ok = (e_rp == m_par);
        end else if (!rst) begin
          for (int i = 1; i <= NREQ; i++)
            if (acc < 0 && bus.req_valid[(m_last + i) % NREQ]) acc = (m_last + i) % NREQ;
          if (acc >= 0) e_ready[acc] = 1'b1;
        end
        check("req_ready",  32'(bus.req_ready),  32'(e_ready));
        check("ser_valid",  32'(bus.ser_valid),  32'(e_sv));
        check("ser_bit",    32'(bus.ser_bit),    32'(e_sb));
        check("res_valid",  32'(bus.res_valid),  32'(e_rv));
        check("res_id",     32'(bus.res_id),     32'(e_id));
        check("res_parity", 32'(bus.res_parity), 32'(e_rp));
        check("res_ok",     32'(bus.res_ok),     32'(e_ok));
        check("busy",       32'(bus.busy),       32'(e_busy));

        if (bus.ser_valid) ser_q.push_back(bus.ser_bit);
        if (bus.res_valid) res_cnt++;
        if (!bus.busy) busy_low_q.push_back(cyc);
        for (int i = 0; i < NREQ; i++)
          if (bus.req_ready[i] && bus.req_valid[i] && !rst) begin
            acc_cyc_q.push_back(cyc);
            acc_id_q.push_back(i);
          end

        if (rst) begin
          m_start = -1;
          m_last  = NREQ - 1;
        end else if (acc >= 0) begin
          m_start = cyc;
          m_word  = bus.req_data[acc*WIDTH +: WIDTH];
          m_par   = bus.req_par[acc];
          m_id    = acc;
          m_last  = acc;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int id, output int ac);
    ac = -1;
    for (int n = 0; n < 200 && ac < 0; n++) begin
      @(negedge clk);
      if (bus.req_ready[id] && bus.req_valid[id] && !rst) ac = cyc;
    end
    check("accept_seen", 32'(ac >= 0), 32'd1);
    tick(1);
  endtask

  task automatic wait_res(output int rc, output int rid, output logic rpar, output logic rok);
    rc = -1; rid = -1; rpar = 0; rok = 0;
    for (int n = 0; n < 100 && rc < 0; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        rc = cyc; rid = int'(bus.res_id); rpar = bus.res_parity; rok = bus.res_ok;
      end
    end
    check("result_seen", 32'(rc >= 0), 32'd1);
    tick(1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    check("idle_seen", 32'(done), 32'd1);
    tick(1);
  endtask

  task automatic wait_accepts(input int count);
    for (int n = 0; n < 200 && acc_id_q.size() < count; n++) @(negedge clk);
    check("accept_count", 32'(acc_id_q.size() >= count), 32'd1);
    tick(1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tr, rid;
    logic rpar, rok;
    logic [7:0] bits;
    int n0;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_par   = '0;
    tick(2);
    mon_en = 1;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_ready",     32'(bus.req_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // req0 = A5, expected even parity 0; inputs scrambled after acceptance.
    ser_q.delete();
    bus.req_data[7:0] = 8'hA5;
    bus.req_par[0]    = 1'b0;
    bus.req_valid[0]  = 1'b1;
    wait_accept(0, ta);
    bus.req_valid[0]  = 1'b0;
    bus.req_data[7:0] = 8'h00;
    bus.req_par[0]    = 1'b1;
    wait_res(tr, rid, rpar, rok);
    bits = '0;
    for (int i = 0; i < 8 && i < ser_q.size(); i++) bits[i] = ser_q[i];
    check("a5_bit_count", 32'(ser_q.size()), 32'd8);
    check("a5_bits",      32'(bits),         32'hA5);
    check("a5_latency",   32'(tr - ta),      32'd9);
    check("a5_id",        32'(rid),          32'd0);
    check("a5_parity",    32'(rpar),         32'd0);
    check("a5_ok",        32'(rok),          32'd1);

    // req1 = 07 with wrong expected parity.
    bus.req_data[15:8] = 8'h07;
    bus.req_par[1]     = 1'b0;
    bus.req_valid[1]   = 1'b1;
    wait_accept(1, ta);
    bus.req_valid[1]   = 1'b0;
    wait_res(tr, rid, rpar, rok);
    check("h07_id",     32'(rid),  32'd1);
    check("h07_parity", 32'(rpar), 32'd1);
    check("h07_ok",     32'(rok),  32'd0);

    // All four held after a reset: round-robin 0,1,2,3 then 0 again.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    acc_cyc_q.delete(); acc_id_q.delete();
    bus.req_data  = {8'h3C, 8'h81, 8'hFF, 8'h5A};
    bus.req_par   = 4'b0110;
    bus.req_valid = 4'b1111;
    wait_accepts(5);
    bus.req_valid = '0;
    for (int i = 0; i < 5 && i < acc_id_q.size(); i++) begin
      check("rr4_id",     32'(acc_id_q[i]),                32'(i % 4));
      check("rr4_offset", 32'(acc_cyc_q[i] - acc_cyc_q[0]), 32'(10 * i));
    end

    // req2/req3 held: alternate 2,3,2,3 with one idle cycle between words.
    acc_cyc_q.delete(); acc_id_q.delete(); busy_low_q.delete();
    bus.req_data[31:16] = {8'h80, 8'h01};
    bus.req_par[3:2]    = 2'b01;
    bus.req_valid       = 4'b1100;
    wait_accepts(4);
    bus.req_valid = '0;
    if (acc_id_q.size() >= 4) begin
      n0 = 0;
      foreach (busy_low_q[i])
        if (busy_low_q[i] > acc_cyc_q[0] && busy_low_q[i] <= acc_cyc_q[3]) n0++;
      check("alt_ids",       {acc_id_q[0][7:0], acc_id_q[1][7:0], acc_id_q[2][7:0], acc_id_q[3][7:0]},
                             32'h02030203);
      check("alt_idle_gaps", 32'(n0), 32'd3);
    end
    wait_idle();

    // Reset during the 4th SHIFT cycle aborts the word and restores the pointer.
    bus.req_data[7:0] = 8'hC3;
    bus.req_valid[0]  = 1'b1;
    wait_accept(0, ta);
    bus.req_valid[0]  = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    n0 = res_cnt;
    tick(12);
    check("abort_no_result", 32'(res_cnt - n0), 32'd0);
    acc_cyc_q.delete(); acc_id_q.delete();
    bus.req_valid = 4'b1001;
    wait_accepts(1);
    bus.req_valid = '0;
    if (acc_id_q.size() >= 1) check("abort_next_grant", 32'(acc_id_q[0]), 32'd0);
    wait_idle();

`ifdef PARITY_ERR_CNT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.req_data[7:0] = 8'h01;
    bus.req_par[0]    = 1'b0;
    bus.req_valid[0]  = 1'b1;
    for (int i = 0; i < 300; i++) wait_accept(0, ta);
    bus.req_valid[0] = 1'b0;
    wait_idle();
    check("err_cnt_req0",   32'(err_cnt[7:0]),  32'd255);
    check("err_cnt_others", 32'(err_cnt[31:8]), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("err_cnt_clear",  32'(err_cnt),       32'd0);
`endif

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
